// File: rtl/uncache_sram_responder_pkg.sv
// Shared types and constants for the uncache SRAM responder.
package uncache_sram_responder_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTES  = WORD_W / 8;

  typedef enum logic [1:0] {
    SR_IDLE = 2'd0,
    SR_ACK  = 2'd1,
    SR_WAIT = 2'd2,
    SR_DONE = 2'd3
  } sr_state_t;

endpackage

// File: rtl/uncache_resp_ram.sv
// Single-port word RAM with byte write enables: synchronous write, combinational read.
module uncache_resp_ram
  import uncache_sram_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic [BYTES-1:0]      we,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [WORD_W-1:0]     wdata,
  output logic [WORD_W-1:0]     rdata
);

  logic [WORD_W-1:0] mem [0:(2**DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < BYTES; i++) begin
      if (we[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/uncache_sram_responder.sv
// Responder end of the uncache request interface: latches one request, waits LATENCY
// cycles after accept, then completes it against the local RAM and pulses fin.
module uncache_sram_responder
  import uncache_sram_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              axi_en,
  input  logic [3:0]        axi_wsel,
  input  logic [31:0]       axi_addr,
  input  logic [31:0]       axi_wdata,
  output logic              accept,
  output logic [31:0]       axi_rdata,
  output logic              fin,
  output logic              busy
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("uncache_sram_responder: LATENCY must be in 1..15");
  end

  sr_state_t             state;
  logic [3:0]            cnt;
  logic [3:0]            wsel_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [31:0]           wdata_q;
  logic [31:0]           ram_rdata;
  logic [3:0]            ram_we;
  logic                  access;
  logic                  capture;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^{axi_addr[31:DEPTH_LOG2+2], axi_addr[1:0]};

  // The counter holds LATENCY-1 during ACK, so ACK plus WAIT span exactly LATENCY cycles.
  assign access  = ((state == SR_ACK) || (state == SR_WAIT)) && (cnt == 4'd0);
  assign capture = axi_en && ((state == SR_IDLE) || (state == SR_DONE));
  assign ram_we  = access ? wsel_q : '0;

  uncache_resp_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= SR_IDLE;
      cnt       <= '0;
      wsel_q    <= '0;
      idx_q     <= '0;
      wdata_q   <= '0;
      accept    <= 1'b0;
      fin       <= 1'b0;
      busy      <= 1'b0;
      axi_rdata <= '0;
    end else begin
      accept <= 1'b0;
      fin    <= 1'b0;
      if (capture) begin
        wsel_q  <= axi_wsel;
        idx_q   <= axi_addr[DEPTH_LOG2+1:2];
        wdata_q <= axi_wdata;
        cnt     <= 4'(LATENCY - 1);
        accept  <= 1'b1;
        busy    <= 1'b1;
        state   <= SR_ACK;
      end else begin
        case (state)
          SR_ACK, SR_WAIT: begin
            if (cnt == 4'd0) begin
              axi_rdata <= (wsel_q == 4'd0) ? ram_rdata : '0;
              fin       <= 1'b1;
              state     <= SR_DONE;
            end else begin
              cnt   <= cnt - 4'd1;
              state <= SR_WAIT;
            end
          end
          SR_DONE: begin
            busy  <= 1'b0;
            state <= SR_IDLE;
          end
          default: state <= SR_IDLE;
        endcase
      end
    end
  end

endmodule
